dac_spi_tx: RTL and testbench



---
 rtl/dac_spi_pkg.sv | 27 ++
 rtl/dac_spi_tx_if.sv | 23 ++
 rtl/sclk_gen.sv | 42 ++++
 rtl/dac_spi_tx.sv | 205 ++++++++++++++++++++
 tb/tb_dac_spi_tx.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI write path.
// Contents: frame geometry, DAC command bytes, FSM state encoding and the
// packed command+data frame layout shifted out MSB first.
package dac_spi_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned CMD_W     = 8;
    localparam int unsigned FRAME_W   = 24;
    localparam int unsigned BIT_CNT_W = 5;

    // Write-and-update: DAC output changes when cs rises.
    localparam logic [CMD_W-1:0] CMD_WRITE_UPDATE = 8'h30;
    // Write input register only: DAC output changes on the LDAC pulse.
    localparam logic [CMD_W-1:0] CMD_WRITE_INPUT  = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_QUIET = 2'd2
    } state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample handshake between the processing datapath and the DAC SPI master.
// Signals: din (sample), din_valid (source has a sample), din_ready (sink
// can take it). Modports: master = sample source, slave = dac_spi_tx.
interface dac_spi_tx_if;
    import dac_spi_pkg::*;

    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );

endinterface

// File: rtl/sclk_gen.sv
// SPI clock divider for dac_spi_tx.
// Ports: clk, rst (sync, active high), en (run while high, clear when low),
// sclk (registered SPI clock, idles low), rise_tick_c / fall_tick_c
// (combinational strobes, high in the cycle whose closing edge moves sclk
// up / down).
module sclk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_tick_c,
    output logic fall_tick_c
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

    logic [DIV_W-1:0] div_cnt;
    logic             sclk_q;
    logic             wrap_c;

    // Half-period elapses on this edge.
    assign wrap_c      = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick_c = wrap_c && !sclk_q;
    assign fall_tick_c = wrap_c &&  sclk_q;
    assign sclk        = sclk_q;

    // Divide counter; held cleared with sclk low whenever disabled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sclk_q  <= 1'b0;
        end else if (wrap_c) begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI write master for the board DAC: takes one 16-bit sample per handshake
// and sends a 24-bit {CMD, sample} frame MSB first in SPI mode 0, then holds
// cs high for a quiet time before taking the next sample.
// Ports: clk, rst (sync, active high), bus (dac_spi_tx_if.slave: din,
// din_valid, din_ready), cs (active low), sclk, mosi, busy, done (one-cycle
// pulse as cs rises), ldac_n (only when DAC_SPI_LDAC_EN is defined).
// Build option: define DAC_SPI_LDAC_EN to add the ldac_n output and default
// CMD to write-input-register-only.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned T_QUIET = 4,
`ifdef DAC_SPI_LDAC_EN
    parameter logic [CMD_W-1:0] CMD = CMD_WRITE_INPUT
`else
    parameter logic [CMD_W-1:0] CMD = CMD_WRITE_UPDATE
`endif
) (
    input  logic        clk,
    input  logic        rst,
    dac_spi_tx_if.slave bus,
    output logic        cs,
    output logic        sclk,
    output logic        mosi,
    output logic        busy,
    output logic        done
`ifdef DAC_SPI_LDAC_EN
    ,
    output logic        ldac_n
`endif
);

    localparam int unsigned QCNT_W = $clog2(T_QUIET + 1);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_SHIFT = 2'(ST_SHIFT);
    localparam logic [1:0] S_QUIET = 2'(ST_QUIET);

    logic [1:0]           state_q,   state_d;
    logic [FRAME_W-1:0]   shreg_q,   shreg_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [QCNT_W-1:0]    q_cnt_q,   q_cnt_d;
    logic                 cs_q,      cs_d;
    logic                 ready_q,   ready_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic                 frame_end_c;
    logic                 rise_tick_c;
    logic                 fall_tick_c;
    logic                 unused_rise;
    frame_t               load_frame_c;

    // Rising sclk edges need no action here: the DAC samples mosi on them.
    assign unused_rise  = rise_tick_c;
    assign load_frame_c = '{cmd: CMD, data: bus.din};

    sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (state_q == S_SHIFT),
        .sclk        (sclk),
        .rise_tick_c (rise_tick_c),
        .fall_tick_c (fall_tick_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        q_cnt_d     = q_cnt_q;
        cs_d        = cs_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_end_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.din_valid && ready_q) begin
                    shreg_d   = load_frame_c;
                    bit_cnt_d = '0;
                    cs_d      = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (fall_tick_c) begin
                    if (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1)) begin
                        // Clearing the register drops mosi with cs.
                        frame_end_c = 1'b1;
                        shreg_d     = '0;
                        cs_d        = 1'b1;
                        done_d      = 1'b1;
                        // ready is raised one cycle ahead so the next handshake
                        // edge falls exactly T_QUIET cycles after cs rise.
                        if (T_QUIET == 1) begin
                            q_cnt_d = '0;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            q_cnt_d = QCNT_W'(1);
                            state_d = S_QUIET;
                        end
                    end else begin
                        shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end

            S_QUIET: begin
                // q_cnt holds cs-high cycles completed by the end of this cycle.
                if (q_cnt_q == QCNT_W'(T_QUIET - 1)) begin
                    q_cnt_d = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    q_cnt_d = q_cnt_q + QCNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            q_cnt_q   <= '0;
            cs_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            q_cnt_q   <= q_cnt_d;
            cs_q      <= cs_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.din_ready = ready_q;
    assign cs            = cs_q;
    assign mosi          = shreg_q[FRAME_W-1];
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef DAC_SPI_LDAC_EN
    localparam int unsigned LDAC_W = $clog2(CLK_DIV + 1);

    logic              ldac_q,     ldac_d;
    logic [LDAC_W-1:0] ldac_cnt_q, ldac_cnt_d;

    // LDAC pulse: low from the cs-rise edge for CLK_DIV cycles.
    always_comb begin
        ldac_d     = ldac_q;
        ldac_cnt_d = ldac_cnt_q;
        if (frame_end_c) begin
            ldac_d     = 1'b0;
            ldac_cnt_d = '0;
        end else if (!ldac_q) begin
            if (ldac_cnt_q == LDAC_W'(CLK_DIV - 1)) begin
                ldac_d     = 1'b1;
                ldac_cnt_d = '0;
            end else begin
                ldac_cnt_d = ldac_cnt_q + LDAC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ldac_q     <= 1'b1;
            ldac_cnt_q <= '0;
        end else begin
            ldac_q     <= ldac_d;
            ldac_cnt_q <= ldac_cnt_d;
        end
    end

    assign ldac_n = ldac_q;
`else
    logic unused_frame_end;
    assign unused_frame_end = frame_end_c;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed self-checking bench for dac_spi_tx.
// Two instances: u_dut with CLK_DIV=2/T_QUIET=4 and u_fast with
// CLK_DIV=1/T_QUIET=1. Define DAC_SPI_LDAC_EN to also cover ldac_n.
module tb_dac_spi_tx;

`ifdef DAC_SPI_LDAC_EN
    localparam logic [7:0] EXP_CMD = 8'h10;
`else
    localparam logic [7:0] EXP_CMD = 8'h30;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_tx_if bus_a ();
    dac_spi_tx_if bus_b ();

    logic cs_a, sclk_a, mosi_a, busy_a, done_a;
    logic cs_b, sclk_b, mosi_b, busy_b, done_b;
`ifdef DAC_SPI_LDAC_EN
    logic ldac_a, ldac_b;
`else
    wire  ldac_a = 1'b1;
    wire  ldac_b = 1'b1;
`endif

    dac_spi_tx #(
        .CLK_DIV (2),
        .T_QUIET (4),
        .CMD     (EXP_CMD)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_a),
        .cs     (cs_a),
        .sclk   (sclk_a),
        .mosi   (mosi_a),
        .busy   (busy_a),
        .done   (done_a)
`ifdef DAC_SPI_LDAC_EN
        ,
        .ldac_n (ldac_a)
`endif
    );

    dac_spi_tx #(
        .CLK_DIV (1),
        .T_QUIET (1),
        .CMD     (EXP_CMD)
    ) u_fast (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_b),
        .cs     (cs_b),
        .sclk   (sclk_b),
        .mosi   (mosi_b),
        .busy   (busy_b),
        .done   (done_b)
`ifdef DAC_SPI_LDAC_EN
        ,
        .ldac_n (ldac_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [15:0] dv, input logic vv);
        if (sel) begin
            bus_b.din       = dv;
            bus_b.din_valid = vv;
        end else begin
            bus_a.din       = dv;
            bus_a.din_valid = vv;
        end
    endtask

    // Follows one frame from cs fall to din_ready return, sampling on negedge.
    // On the first cs-low sample drives (nd, nv); optionally pokes poke_din
    // with a one-cycle valid at cs-low sample number poke_at.
    task automatic watch(input bit sel, input logic [15:0] nd, input logic nv,
                         input int poke_at, input logic [15:0] poke_din,
                         output logic [23:0] frame, output int cs_low,
                         output int rises, output int toggles, output int dones,
                         output int done_at_rise, output int high_to_ready,
                         output int viol, output int busy_bad,
                         output int ldac_low, output int ldac_at_rise,
                         output int t_start);
        int   ph;
        logic c, s, m, d, r, b, l, prev_s;
        frame = '0; cs_low = 0; rises = 0; toggles = 0; dones = 0;
        done_at_rise = 0; high_to_ready = 0; viol = 0; busy_bad = 0;
        ldac_low = 0; ldac_at_rise = 0; t_start = 0;
        ph = 0; prev_s = 1'b0;
        for (int i = 0; i < 400 && ph != 3; i++) begin
            @(negedge clk);
            c = sel ? cs_b   : cs_a;
            s = sel ? sclk_b : sclk_a;
            m = sel ? mosi_b : mosi_a;
            d = sel ? done_b : done_a;
            b = sel ? busy_b : busy_a;
            l = sel ? ldac_b : ldac_a;
            r = sel ? bus_b.din_ready : bus_a.din_ready;
            if (d) dones++;
            if (!l) ldac_low++;
            if (c && (s || m)) viol++;
            if (!c && !b) busy_bad++;
            case (ph)
                0: if (!c) begin
                    ph = 1;
                    t_start = cyc;
                    cs_low = 1;
                    drive(sel, nd, nv);
                end
                1: if (!c) begin
                    cs_low++;
                    if (s && !prev_s) begin
                        frame = {frame[22:0], m};
                        rises++;
                    end
                    if (s != prev_s) toggles++;
                    if (poke_at != 0 && cs_low == poke_at) drive(sel, poke_din, 1'b1);
                    if (poke_at != 0 && cs_low == poke_at + 1) drive(sel, poke_din, 1'b0);
                end else begin
                    ph = 2;
                    done_at_rise = int'(d);
                    ldac_at_rise = int'(!l);
                    high_to_ready = 1;
                    if (r) ph = 3;
                end
                2: begin
                    high_to_ready++;
                    if (r) ph = 3;
                end
                default: ;
            endcase
            prev_s = s;
        end
        check("watch_complete", 32'(ph), 32'd3);
    endtask

    logic [23:0] fr, fr2;
    int csl, ris, tog, dn, dar, h2r, vio, bb, ll, lar, ts, ts2;
    int r10, spur;
    logic ps;

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        drive(1'b1, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_ready",  32'(bus_a.din_ready), 32'd1);
        check("rst_cs",     32'(cs_a),            32'd1);
        check("rst_sclk",   32'(sclk_a),          32'd0);
        check("rst_mosi",   32'(mosi_a),          32'd0);
        check("rst_busy",   32'(busy_a),          32'd0);
        check("rst_done",   32'(done_a),          32'd0);
        check("rst_cs_b",   32'(cs_b),            32'd1);
        check("rst_ldac",   32'(ldac_a),          32'd1);

        // Single frame, defaults.
        rst = 1'b0;
        drive(1'b0, 16'hA5C3, 1'b1);
        watch(1'b0, 16'hA5C3, 1'b0, 0, 16'h0, fr, csl, ris, tog, dn, dar, h2r, vio, bb, ll, lar, ts);
        check("t1_frame",       32'(fr),  {8'h00, EXP_CMD, 16'hA5C3});
        check("t1_cs_low",      32'(csl), 32'd96);
        check("t1_rises",       32'(ris), 32'd24);
        check("t1_dones",       32'(dn),  32'd1);
        check("t1_done_at_rise",32'(dar), 32'd1);
        check("t1_high_to_rdy", 32'(h2r), 32'd4);
        check("t1_idle_pins",   32'(vio), 32'd0);
        check("t1_busy_frame",  32'(bb),  32'd0);
        check("t1_busy_end",    32'(busy_a), 32'd0);

        // Back-to-back with valid held.
        drive(1'b0, 16'h0000, 1'b1);
        watch(1'b0, 16'hFFFF, 1'b1, 0, 16'h0, fr, csl, ris, tog, dn, dar, h2r, vio, bb, ll, lar, ts);
        watch(1'b0, 16'hFFFF, 1'b0, 0, 16'h0, fr2, csl, ris, tog, dn, dar, h2r, vio, bb, ll, lar, ts2);
        check("t2_frame0",      32'(fr),  {8'h00, EXP_CMD, 16'h0000});
        check("t2_frame1",      32'(fr2), {8'h00, EXP_CMD, 16'hFFFF});
        check("t2_spacing",     32'(ts2 - ts), 32'd100);
        check("t2_gap_pins",    32'(vio), 32'd0);
        check("t2_rises",       32'(ris), 32'd24);

        // Fast instance: CLK_DIV=1, T_QUIET=1.
        drive(1'b1, 16'h8001, 1'b1);
        watch(1'b1, 16'h8001, 1'b0, 0, 16'h0, fr, csl, ris, tog, dn, dar, h2r, vio, bb, ll, lar, ts);
        check("t3_frame",       32'(fr),  {8'h00, EXP_CMD, 16'h8001});
        check("t3_cs_low",      32'(csl), 32'd48);
        check("t3_rises",       32'(ris), 32'd24);
        check("t3_toggles",     32'(tog), 32'd47);
        check("t3_high_to_rdy", 32'(h2r), 32'd1);
        check("t3_dones",       32'(dn),  32'd1);

        // Reset at the 10th sclk rise.
        drive(1'b0, 16'h5555, 1'b1);
        r10 = 0;
        ps  = 1'b0;
        for (int i = 0; i < 200 && r10 < 10; i++) begin
            @(negedge clk);
            if (!cs_a) bus_a.din_valid = 1'b0;
            if (sclk_a && !ps) r10++;
            ps = sclk_a;
        end
        check("t4_rise10", 32'(r10), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        check("t4_cs",    32'(cs_a),            32'd1);
        check("t4_sclk",  32'(sclk_a),          32'd0);
        check("t4_mosi",  32'(mosi_a),          32'd0);
        check("t4_ready", 32'(bus_a.din_ready), 32'd1);
        check("t4_done",  32'(done_a),          32'd0);
        rst  = 1'b0;
        spur = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_a || !cs_a) spur++;
        end
        check("t4_quiet_after_rst", 32'(spur), 32'd0);
        drive(1'b0, 16'h1234, 1'b1);
        watch(1'b0, 16'h1234, 1'b0, 0, 16'h0, fr, csl, ris, tog, dn, dar, h2r, vio, bb, ll, lar, ts);
        check("t4_frame",   32'(fr),  {8'h00, EXP_CMD, 16'h1234});
        check("t4_cs_low",  32'(csl), 32'd96);
        check("t4_dones",   32'(dn),  32'd1);

        // din change and valid pulse mid-frame are ignored.
        drive(1'b0, 16'h0F0F, 1'b1);
        watch(1'b0, 16'h0F0F, 1'b0, 30, 16'hF0F0, fr, csl, ris, tog, dn, dar, h2r, vio, bb, ll, lar, ts);
        check("t5_frame",   32'(fr),  {8'h00, EXP_CMD, 16'h0F0F});
        check("t5_rises",   32'(ris), 32'd24);
        check("t5_dones",   32'(dn),  32'd1);
        spur = 0;
        repeat (150) begin
            @(negedge clk);
            if (!cs_a || done_a) spur++;
        end
        check("t5_no_extra_frame", 32'(spur), 32'd0);

`ifdef DAC_SPI_LDAC_EN
        // LDAC pulse after a write-input-register frame.
        drive(1'b0, 16'h00FF, 1'b1);
        watch(1'b0, 16'h00FF, 1'b0, 0, 16'h0, fr, csl, ris, tog, dn, dar, h2r, vio, bb, ll, lar, ts);
        check("t6_frame",        32'(fr),  32'h001000FF);
        check("t6_ldac_low",     32'(ll),  32'd2);
        check("t6_ldac_at_rise", 32'(lar), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
